fetch_pc_gen: RTL
=================

// Module: fetch_pc_gen
// PURPOSE
//  Parametrised fetch-PC generator; successor to the single-PC register.
//  Produces one fetch-block address per cycle toward the I-cache over a valid/ready handshake.
//  Arbitrates N prioritised redirect sources (exception flush, branch, ...).
//  Buffers a redirect that arrives while the fetch port is stalled.
//  Tags each request with an epoch so downstream logic can drop stale responses.
// PARAMETERS
//  ADDR_W        32            address width
//  RESET_PC      32'hbfc00000  first fetch address after reset
//  FETCH_WIDTH   1             instructions per fetch block (1, 2, 4; power of 2)
//  NUM_REDIRECT  2             redirect sources; index 0 = highest priority
//  EPOCH_W       3             epoch tag width
// PORTS
//  clk            in   1                     clock
//  rst            in   1                     synchronous, active-high reset
//  redirect_valid in   NUM_REDIRECT          per-source redirect request
//  redirect_pc    in   NUM_REDIRECT*ADDR_W   per-source target; slice i = [i*ADDR_W +: ADDR_W]
//  req_valid      out  1                     fetch request valid
//  req_ready      in   1                     I-cache accepts request
//  req_pc         out  ADDR_W                fetch address (first valid slot)
//  req_mask       out  FETCH_WIDTH           valid instruction slots within the block
//  req_epoch      out  EPOCH_W               epoch of this request
// BEHAVIOUR
//  State: cur_pc (ADDR_W), pend_valid, pend_pc (ADDR_W), epoch_q (EPOCH_W).
//  Reset values:
//   - cur_pc=RESET_PC, pend_valid=0, epoch_q=0.
//   - req_valid=0 while rst is high; outputs are don't-care then.
//   - First cycle after reset: req_valid=1, req_pc=RESET_PC, req_epoch=0.
//   - Reset mid-stall discards any pending redirect.
//  Selection (combinational, zero latency; a redirect appears on req_pc in the same cycle):
//   - any_redir = |redirect_valid.
//   - sel_pc = redirect_pc of the lowest-index asserted source.
//   - req_pc = any_redir ? sel_pc : pend_valid ? pend_pc : cur_pc.
//  req_valid = !rst (the generator never idles).
//  Block alignment: BB = FETCH_WIDTH*4 bytes; off = req_pc[log2(BB)-1:2].
//   - req_mask[k] = (k >= off).
//   - req_pc[1:0] is passed through unchanged; misalignment is trapped downstream.
//  Handshake fire = req_valid & req_ready. On fire:
//   - cur_pc <= (req_pc & ~(BB-1)) + BB, i.e. the next block boundary.
//   - Addition is mod 2^ADDR_W (0xFFFFFFFC + 4 wraps to 0).
//   - pend_valid <= 0.
//  No fire with any_redir:
//   - pend_valid <= 1, pend_pc <= sel_pc; cur_pc holds.
//   - A newer redirect always overwrites an older pending one.
//  No fire, no redirect: all state holds; req_pc stays stable while stalled.
//  Epoch:
//   - req_epoch = any_redir ? epoch_q+1 : epoch_q.
//   - epoch_q <= req_epoch every non-reset cycle.
//   - At most one increment per cycle regardless of source count; wraps mod 2^EPOCH_W.
//  Simultaneous redirect and fire: the redirect target is fetched this cycle; nothing is pended.
// STRUCTURE
//  Shared package gugu_fetch_pkg:
//   - localparam RESET_PC_DEFAULT.
//   - typedef addr_t.
//   - typedef epoch_t.
//   - function next_block(addr, fw) returning the next block boundary.
//  Sub-module redirect_arb #(NUM_REDIRECT, ADDR_W):
//   - fixed-priority one-hot select.
//   - outputs any_redir and sel_pc.
//  Top level: state registers, mask decode, epoch counter.
// TESTING
//  1. Reset, ready=1, FW=1: req_pc bfc00000, bfc00004, bfc00008; epoch 0; mask 1'b1.
//  2. FW=4, redirect[1] to 0x8000_0008 with ready=1:
//     - same cycle: req_pc=80000008, mask=4'b1100, epoch=1.
//     - next cycle: req_pc=80000010, mask=4'b1111.
//  3. Both sources valid (0 -> 0x80000180, 1 -> 0x80001000): req_pc=80000180; epoch increments by exactly 1.
//  4. ready=0 for 3 cycles, redirect[1]=0x1000 in cycle 1, redirect[0]=0x2000 in cycle 2:
//     - req_pc stays 0x2000 after cycle 2.
//     - with ready=1: fire at 0x2000, then 0x2004; pend_valid clears.
//  5. Redirect to 0xFFFF_FFFC, FW=1, ready=1: next req_pc=0x0000_0000 (wrap).
//  6. Redirect pended under ready=0, then rst asserted:
//     - req_valid=0 during rst.
//     - after rst: req_pc=RESET_PC, epoch 0, pending discarded.

Source files
------------

// File: rtl/gugu_fetch_pkg.sv
// Shared fetch-path types and helpers: default reset vector, address/epoch types,
// and the next-fetch-block computation.
package gugu_fetch_pkg;

  localparam int unsigned ADDR_W_DEFAULT  = 32;
  localparam int unsigned EPOCH_W_DEFAULT = 3;
  localparam logic [ADDR_W_DEFAULT-1:0] RESET_PC_DEFAULT = 32'hbfc0_0000;

  typedef logic [ADDR_W_DEFAULT-1:0]  addr_t;
  typedef logic [EPOCH_W_DEFAULT-1:0] epoch_t;

  // Align down to the fetch block and step one block; wraps mod 2^ADDR_W.
  function automatic addr_t next_block(input addr_t addr, input int unsigned fw);
    addr_t bb;
    bb = addr_t'(fw * 4);
    return (addr & ~(bb - addr_t'(1))) + bb;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch-PC generator bus: redirect inputs plus the I-cache request handshake.
interface fetch_pc_gen_if #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FETCH_WIDTH  = 1,
  parameter int unsigned NUM_REDIRECT = 2,
  parameter int unsigned EPOCH_W      = 3
);

  logic [NUM_REDIRECT-1:0]        redirect_valid;
  logic [NUM_REDIRECT*ADDR_W-1:0] redirect_pc;
  logic                           req_valid;
  logic                           req_ready;
  logic [ADDR_W-1:0]              req_pc;
  logic [FETCH_WIDTH-1:0]         req_mask;
  logic [EPOCH_W-1:0]             req_epoch;

  modport master (
    input  redirect_valid, redirect_pc, req_ready,
    output req_valid, req_pc, req_mask, req_epoch
  );

  modport slave (
    output redirect_valid, redirect_pc, req_ready,
    input  req_valid, req_pc, req_mask, req_epoch
  );

endinterface

// File: rtl/redirect_arb.sv
// Fixed-priority redirect arbiter: source 0 wins; purely combinational.
module redirect_arb #(
  parameter int unsigned NUM_REDIRECT = 2,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic [NUM_REDIRECT-1:0]        redirect_valid,
  input  logic [NUM_REDIRECT*ADDR_W-1:0] redirect_pc,
  output logic                           any_redir,
  output logic [ADDR_W-1:0]              sel_pc
);

  logic [NUM_REDIRECT-1:0] grant;

  // Isolate the lowest set bit to get a one-hot grant, then AND-OR mux.
  always_comb begin
    grant     = redirect_valid & ~(redirect_valid - NUM_REDIRECT'(1));
    any_redir = |redirect_valid;
    sel_pc    = '0;
    for (int i = 0; i < int'(NUM_REDIRECT); i++) begin
      sel_pc = sel_pc | ({ADDR_W{grant[i]}} & redirect_pc[i*ADDR_W +: ADDR_W]);
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-PC generator: one block address per cycle, prioritised redirects,
// stall-time redirect buffering and epoch tagging of every request.
module fetch_pc_gen
  import gugu_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_PC     = ADDR_W'(RESET_PC_DEFAULT),
  parameter int unsigned       FETCH_WIDTH  = 1,
  parameter int unsigned       NUM_REDIRECT = 2,
  parameter int unsigned       EPOCH_W      = 3
) (
  input logic             clk,
  input logic             rst,
  fetch_pc_gen_if.master  bus
);

  localparam int unsigned BB    = FETCH_WIDTH * 4;
  localparam int unsigned OFF_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

  logic               any_redir;
  logic [ADDR_W-1:0]  sel_pc;
  logic [ADDR_W-1:0]  cur_pc;
  logic               pend_valid;
  logic [ADDR_W-1:0]  pend_pc;
  logic [EPOCH_W-1:0] epoch_q;

  logic [ADDR_W-1:0]      req_pc_c;
  logic [ADDR_W-1:0]      next_pc_c;
  logic [EPOCH_W-1:0]     req_epoch_c;
  logic [FETCH_WIDTH-1:0] mask_c;
  logic                   fire_c;

  redirect_arb #(
    .NUM_REDIRECT (NUM_REDIRECT),
    .ADDR_W       (ADDR_W)
  ) u_arb (
    .redirect_valid (bus.redirect_valid),
    .redirect_pc    (bus.redirect_pc),
    .any_redir      (any_redir),
    .sel_pc         (sel_pc)
  );

  // A live redirect beats a buffered one, which beats sequential fetch.
  always_comb begin
    req_pc_c = cur_pc;
    if (any_redir)       req_pc_c = sel_pc;
    else if (pend_valid) req_pc_c = pend_pc;
    req_epoch_c = any_redir ? epoch_q + EPOCH_W'(1) : epoch_q;
    fire_c      = !rst && bus.req_ready;
  end

  if (ADDR_W == ADDR_W_DEFAULT) begin : g_next_pkg
    assign next_pc_c = ADDR_W'(next_block(addr_t'(req_pc_c), FETCH_WIDTH));
  end else begin : g_next_generic
    assign next_pc_c = (req_pc_c & ~ADDR_W'(BB - 1)) + ADDR_W'(BB);
  end

  // Slots before the entry offset within the block are masked off.
  if (FETCH_WIDTH == 1) begin : g_mask_single
    assign mask_c = 1'b1;
  end else begin : g_mask_multi
    logic [OFF_W-1:0] off;
    assign off = req_pc_c[OFF_W+1:2];
    for (genvar k = 0; k < int'(FETCH_WIDTH); k++) begin : g_slot
      assign mask_c[k] = (OFF_W'(k) >= off);
    end
  end

  assign bus.req_valid = !rst;
  assign bus.req_pc    = req_pc_c;
  assign bus.req_mask  = mask_c;
  assign bus.req_epoch = req_epoch_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_pc     <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      epoch_q    <= '0;
    end else begin
      epoch_q <= req_epoch_c;
      if (fire_c) begin
        cur_pc     <= next_pc_c;
        pend_valid <= 1'b0;
      end else if (any_redir) begin
        pend_valid <= 1'b1;
        pend_pc    <= sel_pc;
      end
    end
  end

endmodule
